// File: rtl/ddr4_pkg.sv
// Shared types and widths for the DDR4 per-request command sequencer.
package ddr4_pkg;

  localparam int ROW_W    = 15;
  localparam int BANK_W   = 2;
  localparam int BG_W     = 2;
  localparam int COL_W    = 10;
  localparam int DATA_W   = 64;
  localparam int BUFFBITS = 3;
  localparam int ADDR_W   = 17;
  localparam int A10      = 10;

  // Scheduler flat-address split: {row, bank, bankgroup, column, byte-in-beat}
  localparam int MAP_BYTE_LSB = 0;
  localparam int MAP_COL_LSB  = 3;
  localparam int MAP_BG_LSB   = MAP_COL_LSB + COL_W;
  localparam int MAP_BA_LSB   = MAP_BG_LSB + BG_W;
  localparam int MAP_ROW_LSB  = MAP_BA_LSB + BANK_W;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PREA, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_COL, S_WAIT_CAS,
    S_BURST, S_WAIT_WR, S_REF, S_WAIT_RFC, S_DONE
  } state_e;

  function automatic logic [ADDR_W-1:0] col_addr(input logic ap,
                                                 input logic [COL_W-1:0] col);
    return {{(ADDR_W-COL_W-1){1'b0}}, ap, col};
  endfunction

endpackage

// File: rtl/ddr4_timer.sv
// Loadable down-counter shared by every wait state of the command sequencer.
module ddr4_timer #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr4_cmd_fsm.sv
// Sequences PRE/ACT/RD/WR/REF for one scheduled request and moves its data burst.
module ddr4_cmd_fsm
  import ddr4_pkg::*;
#(
  parameter int T_RP  = 4,
  parameter int T_RCD = 4,
  parameter int T_CL  = 5,
  parameter int T_CWL = 4,
  parameter int T_BL  = 4,
  parameter int T_WR  = 5,
  parameter int T_RFC = 20,
  parameter int CNTW  = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                rw_out,
  input  logic                refresh,
  input  logic                ap,
  input  logic                PageMiss,
  input  logic                PageEmpty,
  input  logic [1:0]          PageHit,
  input  logic [ROW_W-1:0]    row,
  input  logic [BANK_W-1:0]   bank,
  input  logic [BG_W-1:0]     bankgroup,
  input  logic [COL_W-1:0]    column,
  input  logic [DATA_W-1:0]   DataOut,
  input  logic [BUFFBITS-1:0] tagread,
  output logic                done,
  output logic                buff,
  output logic [BUFFBITS-1:0] tagfsm,
  output cmd_e                cmd,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [BANK_W-1:0]   cmd_ba,
  output logic [BG_W-1:0]     cmd_bg,
  output logic [DATA_W-1:0]   dq_out,
  output logic                dq_oe,
  input  logic [DATA_W-1:0]   dq_in,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output state_e              dbg_state
);

  // Handshake: start is accepted only in a cycle where buff=1 (IDLE); a start
  // seen while buff=0 is dropped. Each accepted start yields exactly one done.
  state_e state, state_next;

  logic                rw_q, refresh_q, ap_q;
  logic [ROW_W-1:0]    row_q;
  logic [BANK_W-1:0]   bank_q;
  logic [BG_W-1:0]     bg_q;
  logic [COL_W-1:0]    col_q;
  logic [DATA_W-1:0]   data_q;
  logic [BUFFBITS-1:0] tag_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                tmr_load, tmr_zero, rd_beat, wr_beat;
  logic [CNTW-1:0]     tmr_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rw_q <= 1'b0; refresh_q <= 1'b0; ap_q <= 1'b0;
      row_q <= '0; bank_q <= '0; bg_q <= '0; col_q <= '0;
      data_q <= '0; tag_q <= '0;
    end else if (state == S_IDLE && start) begin
      rw_q <= rw_out; refresh_q <= refresh; ap_q <= ap;
      row_q <= row; bank_q <= bank; bg_q <= bankgroup; col_q <= column;
      data_q <= DataOut; tag_q <= tagread;
    end
  end

  assign rd_beat = (state == S_BURST) && rw_q;
  assign wr_beat = (state == S_BURST) && !rw_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       rdata_q <= '0;
    else if (rd_beat) rdata_q <= dq_in;
  end

  // A timing parameter of 1 means the command itself covers the gap, so the
  // wait state is skipped entirely.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) begin
        if (refresh)        state_next = S_PREA;
        else if (PageMiss)  state_next = S_PRE;
        else if (PageEmpty) state_next = S_ACT;
        else if (|PageHit)  state_next = S_COL;
        else                state_next = S_ACT;
      end
      S_PRE:      state_next = (T_RP > 1) ? S_WAIT_RP : S_ACT;
      S_PREA:     state_next = (T_RP > 1) ? S_WAIT_RP : S_REF;
      S_WAIT_RP:  if (tmr_zero) state_next = refresh_q ? S_REF : S_ACT;
      S_ACT:      state_next = (T_RCD > 1) ? S_WAIT_RCD : S_COL;
      S_WAIT_RCD: if (tmr_zero) state_next = S_COL;
      S_COL:      state_next = ((rw_q ? T_CL : T_CWL) > 1) ? S_WAIT_CAS : S_BURST;
      S_WAIT_CAS: if (tmr_zero) state_next = S_BURST;
      S_BURST:    if (tmr_zero)
                    state_next = (!rw_q && ap_q && T_WR > 0) ? S_WAIT_WR : S_DONE;
      S_WAIT_WR:  if (tmr_zero) state_next = S_DONE;
      S_REF:      state_next = (T_RFC > 1) ? S_WAIT_RFC : S_DONE;
      S_WAIT_RFC: if (tmr_zero) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // The counter is reloaded on every state change, so each state sees a fresh count.
  assign tmr_load = (state_next != state);

  always_comb begin
    tmr_val = '0;
    case (state_next)
      S_WAIT_RP:  tmr_val = CNTW'(T_RP - 2);
      S_WAIT_RCD: tmr_val = CNTW'(T_RCD - 2);
      S_WAIT_CAS: tmr_val = rw_q ? CNTW'(T_CL - 2) : CNTW'(T_CWL - 2);
      S_BURST:    tmr_val = CNTW'(T_BL - 1);
      S_WAIT_WR:  tmr_val = CNTW'(T_WR - 1);
      S_WAIT_RFC: tmr_val = CNTW'(T_RFC - 2);
      default:    tmr_val = '0;
    endcase
  end

  ddr4_timer #(.W(CNTW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    cmd      = CMD_NOP;
    cmd_addr = '0;
    cmd_ba   = '0;
    cmd_bg   = '0;
    case (state)
      S_PRE: begin
        cmd = CMD_PRE; cmd_ba = bank_q; cmd_bg = bg_q;
      end
      S_PREA: begin
        cmd = CMD_PREA; cmd_addr[A10] = 1'b1;
      end
      S_ACT: begin
        cmd = CMD_ACT; cmd_addr = ADDR_W'(row_q); cmd_ba = bank_q; cmd_bg = bg_q;
      end
      S_COL: begin
        cmd = rw_q ? CMD_RD : CMD_WR;
        cmd_addr = col_addr(ap_q, col_q); cmd_ba = bank_q; cmd_bg = bg_q;
      end
      S_REF:   cmd = CMD_REF;
      default: cmd = CMD_NOP;
    endcase
  end

  assign buff      = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign tagfsm    = done ? tag_q : '0;
  assign dq_oe     = wr_beat;
  assign dq_out    = wr_beat ? data_q : '0;
  assign rvalid    = rd_beat;
  assign rdata     = rd_beat ? dq_in : rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ddr4_cmd_fsm.sv
// Directed plus randomized bench for ddr4_cmd_fsm against a timeline model of each request.
module tb_ddr4_cmd_fsm;
  import ddr4_pkg::*;

  localparam int T_RP = 4, T_RCD = 4, T_CL = 5, T_CWL = 4, T_BL = 4, T_WR = 5, T_RFC = 20;

  logic clock, reset, start, rw_out, refresh, ap, PageMiss, PageEmpty;
  logic [1:0]  PageHit, bank, bankgroup, cmd_ba, cmd_bg;
  logic [14:0] row;
  logic [9:0]  column;
  logic [63:0] DataOut, dq_out, dq_in, rdata;
  logic [2:0]  tagread, tagfsm;
  logic [16:0] cmd_addr;
  logic        done, buff, dq_oe, rvalid;
  cmd_e        cmd;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  ddr4_cmd_fsm #(
    .T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL), .T_CWL(T_CWL),
    .T_BL(T_BL), .T_WR(T_WR), .T_RFC(T_RFC), .CNTW(6)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .rw_out(rw_out), .refresh(refresh),
    .ap(ap), .PageMiss(PageMiss), .PageEmpty(PageEmpty), .PageHit(PageHit),
    .row(row), .bank(bank), .bankgroup(bankgroup), .column(column),
    .DataOut(DataOut), .tagread(tagread), .done(done), .buff(buff), .tagfsm(tagfsm),
    .cmd(cmd), .cmd_addr(cmd_addr), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in), .rdata(rdata), .rvalid(rvalid),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cmd_word(input int k, input logic [2:0] c,
      input logic [1:0] ba, input logic [1:0] bg, input logic [16:0] a);
    logic [7:0] kk;
    kk = k[7:0];
    return {kk, c, ba, bg, a};
  endfunction

  // Drivers
  task automatic scramble_inputs();
    rw_out = 1'($urandom); refresh = 1'($urandom); ap = 1'($urandom);
    PageMiss = 1'($urandom); PageEmpty = 1'($urandom); PageHit = 2'($urandom);
    row = 15'($urandom); bank = 2'($urandom); bankgroup = 2'($urandom);
    column = 10'($urandom); DataOut = {$urandom, $urandom}; tagread = 3'($urandom);
  endtask

  // One request: the model lays out the command/data timeline (cycle 1 is the
  // cycle after start is sampled), then the DUT is watched cycle by cycle.
  task automatic run_txn(input logic t_rw, input logic t_ref, input logic t_ap,
      input logic t_miss, input logic t_empty, input logic [1:0] t_hit,
      input logic [14:0] t_row, input logic [1:0] t_ba, input logic [1:0] t_bg,
      input logic [9:0] t_col, input logic [63:0] t_data, input logic [2:0] t_tag,
      input int stray_k);
    int k, b0, t_done;
    logic beat;
    logic [31:0] w, got;
    logic [63:0] last_rd;
    exp_q.delete();
    b0 = -1;
    last_rd = '0;
    if (t_ref) begin
      exp_q.push_back(cmd_word(1, CMD_PREA, 2'd0, 2'd0, 17'h00400));
      exp_q.push_back(cmd_word(1 + T_RP, CMD_REF, 2'd0, 2'd0, 17'h0));
      t_done = 1 + T_RP + T_RFC;
    end else begin
      k = 1;
      if (t_miss) begin
        exp_q.push_back(cmd_word(k, CMD_PRE, t_ba, t_bg, 17'h0));
        k += T_RP;
      end
      if (t_miss || t_empty || t_hit == 2'd0) begin
        exp_q.push_back(cmd_word(k, CMD_ACT, t_ba, t_bg, {2'b00, t_row}));
        k += T_RCD;
      end
      exp_q.push_back(cmd_word(k, t_rw ? CMD_RD : CMD_WR, t_ba, t_bg, {6'b0, t_ap, t_col}));
      b0 = k + (t_rw ? T_CL : T_CWL);
      t_done = b0 + T_BL + ((!t_rw && t_ap) ? T_WR : 0);
    end

    check("idle_buff_before_start", buff, 1'b1);
    @(posedge clock); #1;
    start = 1'b1; rw_out = t_rw; refresh = t_ref; ap = t_ap;
    PageMiss = t_miss; PageEmpty = t_empty; PageHit = t_hit;
    row = t_row; bank = t_ba; bankgroup = t_bg; column = t_col;
    DataOut = t_data; tagread = t_tag;

    for (int c = 1; c <= t_done + 1; c++) begin
      @(posedge clock); #1;
      scramble_inputs();
      start = (c == stray_k);
      dq_in = {$urandom, $urandom};
      @(negedge clock);
      beat = (b0 > 0) && (c >= b0) && (c < b0 + T_BL);
      got = cmd_word(c, cmd, cmd_ba, cmd_bg, cmd_addr);
      if (exp_q.size() > 0 && exp_q[0][31:24] == c[7:0]) begin
        w = exp_q.pop_front();
        check("cmd_issue", got, w);
      end else begin
        check("cmd_nop", cmd, CMD_NOP);
      end
      check("dq_oe", dq_oe, beat && !t_rw);
      if (beat && !t_rw) check("dq_out", dq_out, t_data);
      check("rvalid", rvalid, beat && t_rw);
      if (beat && t_rw) begin
        check("rdata_beat", rdata, dq_in);
        last_rd = dq_in;
      end
      check("done", done, c == t_done);
      if (c == t_done) begin
        check("tagfsm", tagfsm, t_tag);
        if (t_rw && !t_ref) check("rdata_hold", rdata, last_rd);
      end
      check("buff", buff, c > t_done);
    end
    start = 1'b0;
    check("cmd_queue_drained", exp_q.size(), 0);
  endtask

  // Stimulus
  initial begin
    logic got_burst;
    start = 1'b1; dq_in = '0;
    scramble_inputs();
    reset = 1'b0;

    // Reset held with start high: quiet outputs throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_cmd", cmd, CMD_NOP);
      check("rst_buff", buff, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_dq_oe", dq_oe, 1'b0);
    end
    start = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("post_rst_cmd", cmd, CMD_NOP);
      check("post_rst_buff", buff, 1'b1);
      check("post_rst_rvalid", rvalid, 1'b0);
    end

    // Read to an empty bank
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 15'h1234, 2'd1, 2'd2, 10'h005,
            64'h0, 3'd5, 0);
    // Write after page miss with auto-precharge
    run_txn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 15'h0abc, 2'd3, 2'd1, 10'h3c7,
            64'hDEADBEEF_CAFEF00D, 3'd2, 0);
    // Refresh wins over a page hit
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 15'h7fff, 2'd2, 2'd3, 10'h3ff,
            64'h0, 3'd7, 0);
    // Page-hit read with a stray start during the burst
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 15'h0001, 2'd0, 2'd0, 10'h2aa,
            64'h0, 3'd3, 1 + T_CL + 1);
    // No page flag: treated as an empty bank
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 15'h4321, 2'd2, 2'd0, 10'h001,
            64'h0123_4567_89ab_cdef, 3'd0, 0);

    // Reset during a write burst
    @(posedge clock); #1;
    start = 1'b1; rw_out = 1'b0; refresh = 1'b0; ap = 1'b1;
    PageMiss = 1'b0; PageEmpty = 1'b1; PageHit = 2'd0; DataOut = 64'h5555_aaaa_5555_aaaa;
    @(posedge clock); #1 start = 1'b0;
    got_burst = 1'b0;
    for (int c = 0; c < 40 && !got_burst; c++) begin
      @(negedge clock);
      if (dq_oe === 1'b1) got_burst = 1'b1;
    end
    check("abort_burst_reached", got_burst, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_dq_oe", dq_oe, 1'b0);
    check("abort_cmd", cmd, CMD_NOP);
    check("abort_done", done, 1'b0);
    check("abort_buff", buff, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("abort_hold_done", done, 1'b0);
      check("abort_hold_cmd", cmd, CMD_NOP);
    end
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_release_done", done, 1'b0);
      check("abort_release_cmd", cmd, CMD_NOP);
      check("abort_release_buff", buff, 1'b1);
    end
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 15'h0f0f, 2'd1, 2'd1, 10'h0f0,
            64'hFEED_FACE_0BAD_BEEF, 3'd6, 0);

    // Randomized requests
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom),
              15'($urandom), 2'($urandom), 2'($urandom), 10'($urandom),
              {$urandom, $urandom}, 3'($urandom),
              ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
